// File: rtl/branch_pred_if.sv
// Fetch-lookup, branch-resolution and perf-debug signals of the branch predictor.
// The core side drives through master; the predictor sits on slave.
interface branch_pred_if #(
  parameter int unsigned XLEN = 32
);
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic            pred_valid;
  logic [XLEN-1:0] pred_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            exu_is_branch;
  logic            exu_branch_taken;
  logic [XLEN-1:0] exu_branch_pc;
  logic [XLEN-1:0] exu_target_pc;
  logic            bp_clear;
  logic [31:0]     perf_branch_cnt;
  logic [31:0]     perf_mispred_cnt;

  modport master (
    output fetch_valid, fetch_pc,
    output exu_is_branch, exu_branch_taken, exu_branch_pc, exu_target_pc,
    output bp_clear,
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  perf_branch_cnt, perf_mispred_cnt
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  exu_is_branch, exu_branch_taken, exu_branch_pc, exu_target_pc,
    input  bp_clear,
    output pred_valid, pred_pc, pred_taken, pred_target,
    output perf_branch_cnt, perf_mispred_cnt
  );
endinterface

// File: rtl/branch_pred.sv
// Bimodal BHT (2-bit saturating counters) plus direct-mapped BTB predictor,
// trained by resolved branches from the EXU, with saturating perf counters.
module branch_pred #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input logic         clk,
  input logic         rst_n,
  branch_pred_if.slave bp
);
  localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);
  localparam int unsigned BTB_IW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W  = XLEN - BTB_IW - 2;

  logic [1:0]       bht_q     [BHT_ENTRIES];
  logic [1:0]       bht_d     [BHT_ENTRIES];
  logic             btb_v_q   [BTB_ENTRIES];
  logic             btb_v_d   [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_d [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_tgt_q [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_tgt_d [BTB_ENTRIES];

  logic             pred_valid_q, pred_valid_d;
  logic [XLEN-1:0]  pred_pc_q, pred_pc_d;
  logic             pred_taken_q, pred_taken_d;
  logic [XLEN-1:0]  pred_target_q, pred_target_d;
  logic [31:0]      perf_branch_cnt_q, perf_branch_cnt_d;
  logic [31:0]      perf_mispred_cnt_q, perf_mispred_cnt_d;

  // Fetch-side lookup against current table state
  logic [BHT_IW-1:0] f_bidx;
  logic [BTB_IW-1:0] f_tidx;
  logic [TAG_W-1:0]  f_tag;
  logic              f_hit, f_taken;
  logic [XLEN-1:0]   f_target;

  // Resolution-side view of the same tables
  logic [BHT_IW-1:0] e_bidx;
  logic [BTB_IW-1:0] e_tidx;
  logic [TAG_W-1:0]  e_tag;
  logic              e_hit, e_pred_taken, e_mispred;

  // pc[1:0] never takes part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^bp.exu_branch_pc[1:0];

  always_comb begin
    f_bidx   = bp.fetch_pc[BHT_IW+1:2];
    f_tidx   = bp.fetch_pc[BTB_IW+1:2];
    f_tag    = bp.fetch_pc[XLEN-1:BTB_IW+2];
    f_hit    = btb_v_q[f_tidx] && (btb_tag_q[f_tidx] == f_tag);
    f_taken  = f_hit && bht_q[f_bidx][1];
    f_target = f_taken ? btb_tgt_q[f_tidx] : bp.fetch_pc + XLEN'(4);
  end

  always_comb begin
    e_bidx       = bp.exu_branch_pc[BHT_IW+1:2];
    e_tidx       = bp.exu_branch_pc[BTB_IW+1:2];
    e_tag        = bp.exu_branch_pc[XLEN-1:BTB_IW+2];
    e_hit        = btb_v_q[e_tidx] && (btb_tag_q[e_tidx] == e_tag);
    e_pred_taken = e_hit && bht_q[e_bidx][1];
    // A taken prediction only counts as correct if its target also matches.
    if (bp.exu_branch_taken)
      e_mispred = !(e_pred_taken && (btb_tgt_q[e_tidx] == bp.exu_target_pc));
    else
      e_mispred = e_pred_taken;
  end

  always_comb begin
    bht_d     = bht_q;
    btb_v_d   = btb_v_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    if (bp.exu_is_branch) begin
      if (bp.exu_branch_taken) begin
        if (bht_q[e_bidx] != 2'b11) bht_d[e_bidx] = bht_q[e_bidx] + 2'd1;
        btb_v_d[e_tidx]   = 1'b1;
        btb_tag_d[e_tidx] = e_tag;
        btb_tgt_d[e_tidx] = bp.exu_target_pc;
      end else if (bht_q[e_bidx] != 2'b00) begin
        bht_d[e_bidx] = bht_q[e_bidx] - 2'd1;
      end
    end
    // Clear overrides any update in the same cycle.
    if (bp.bp_clear) begin
      bht_d   = '{default: 2'b01};
      btb_v_d = '{default: 1'b0};
    end
  end

  always_comb begin
    pred_valid_d  = bp.fetch_valid;
    pred_pc_d     = pred_pc_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (bp.fetch_valid) begin
      pred_pc_d     = bp.fetch_pc;
      pred_taken_d  = f_taken;
      pred_target_d = f_target;
    end
  end

  always_comb begin
    perf_branch_cnt_d  = perf_branch_cnt_q;
    perf_mispred_cnt_d = perf_mispred_cnt_q;
    if (bp.exu_is_branch && (perf_branch_cnt_q != '1))
      perf_branch_cnt_d = perf_branch_cnt_q + 32'd1;
    if (bp.exu_is_branch && e_mispred && (perf_mispred_cnt_q != '1))
      perf_mispred_cnt_d = perf_mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bht_q              <= '{default: 2'b01};
      btb_v_q            <= '{default: 1'b0};
      btb_tag_q          <= '{default: '0};
      btb_tgt_q          <= '{default: '0};
      pred_valid_q       <= 1'b0;
      pred_pc_q          <= '0;
      pred_taken_q       <= 1'b0;
      pred_target_q      <= '0;
      perf_branch_cnt_q  <= '0;
      perf_mispred_cnt_q <= '0;
    end else begin
      bht_q              <= bht_d;
      btb_v_q            <= btb_v_d;
      btb_tag_q          <= btb_tag_d;
      btb_tgt_q          <= btb_tgt_d;
      pred_valid_q       <= pred_valid_d;
      pred_pc_q          <= pred_pc_d;
      pred_taken_q       <= pred_taken_d;
      pred_target_q      <= pred_target_d;
      perf_branch_cnt_q  <= perf_branch_cnt_d;
      perf_mispred_cnt_q <= perf_mispred_cnt_d;
    end
  end

  assign bp.pred_valid       = pred_valid_q;
  assign bp.pred_pc          = pred_pc_q;
  assign bp.pred_taken       = pred_taken_q;
  assign bp.pred_target      = pred_target_q;
  assign bp.perf_branch_cnt  = perf_branch_cnt_q;
  assign bp.perf_mispred_cnt = perf_mispred_cnt_q;
endmodule

// File: tb/tb_branch_pred.sv
// Directed scenarios plus randomized traffic for branch_pred, checked against
// an array-based model of the predictor rules.
module tb_branch_pred;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NBHT = 64;
  localparam int unsigned NBTB = 16;

  logic clk;
  logic rst_n;
  branch_pred_if #(.XLEN(XLEN)) bp ();

  branch_pred #(.XLEN(XLEN), .BHT_ENTRIES(NBHT), .BTB_ENTRIES(NBTB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bp   (bp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Model: counters as ints, BTB entries remember the full branch pc.
  int unsigned m_ctr [NBHT];
  bit          m_v   [NBTB];
  bit [31:0]   m_pc  [NBTB];
  bit [31:0]   m_tgt [NBTB];
  bit [31:0]   m_br, m_mp;
  bit          m_pv, m_ptk;
  bit [31:0]   m_ppc, m_ptgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void m_reset_tables();
    for (int i = 0; i < NBHT; i++) m_ctr[i] = 1;
    for (int i = 0; i < NBTB; i++) m_v[i] = 1'b0;
  endfunction

  function automatic void m_reset_all();
    m_reset_tables();
    m_br = 0; m_mp = 0;
    m_pv = 0; m_ptk = 0; m_ppc = 0; m_ptgt = 0;
  endfunction

  function automatic void m_predict(input bit [31:0] pc, output bit tk, output bit [31:0] tgt);
    int unsigned bi, ti;
    bit hit;
    bi  = (pc >> 2) % NBHT;
    ti  = (pc >> 2) % NBTB;
    hit = m_v[ti] && ((m_pc[ti] >> 6) == (pc >> 6));
    tk  = hit && (m_ctr[bi] >= 2);
    tgt = tk ? m_tgt[ti] : pc + 32'd4;
  endfunction

  task automatic check_outputs(input string tag, input bit chk_perf);
    chk({tag, "_pv"}, {31'd0, bp.pred_valid}, {31'd0, m_pv});
    chk({tag, "_ppc"}, bp.pred_pc, m_ppc);
    chk({tag, "_ptk"}, {31'd0, bp.pred_taken}, {31'd0, m_ptk});
    chk({tag, "_ptgt"}, bp.pred_target, m_ptgt);
    if (chk_perf) begin
      chk({tag, "_nbr"}, bp.perf_branch_cnt, m_br);
      chk({tag, "_nmp"}, bp.perf_mispred_cnt, m_mp);
    end
  endtask

  // One clock: drive, advance the model, clock, compare.
  task automatic step(input string tag, input bit fv, input bit [31:0] fpc,
                      input bit br, input bit tk, input bit [31:0] bpc,
                      input bit [31:0] btgt, input bit clr, input bit chk_perf);
    bit ptk, mis;
    bit [31:0] ptg;
    int unsigned bi, ti;
    bp.fetch_valid      = fv;
    bp.fetch_pc         = fpc;
    bp.exu_is_branch    = br;
    bp.exu_branch_taken = tk;
    bp.exu_branch_pc    = bpc;
    bp.exu_target_pc    = btgt;
    bp.bp_clear         = clr;
    m_pv = fv;
    if (fv) begin
      m_predict(fpc, ptk, ptg);
      m_ppc = fpc; m_ptk = ptk; m_ptgt = ptg;
    end
    if (br) begin
      m_predict(bpc, ptk, ptg);
      mis = tk ? !(ptk && ptg == btgt) : ptk;
      if (m_br != 32'hFFFF_FFFF) m_br++;
      if (mis && m_mp != 32'hFFFF_FFFF) m_mp++;
      bi = (bpc >> 2) % NBHT;
      ti = (bpc >> 2) % NBTB;
      if (tk) begin
        if (m_ctr[bi] < 3) m_ctr[bi]++;
        m_v[ti] = 1'b1; m_pc[ti] = bpc; m_tgt[ti] = btgt;
      end else if (m_ctr[bi] > 0) begin
        m_ctr[bi]--;
      end
    end
    if (clr) m_reset_tables();
    @(posedge clk);
    #1;
    check_outputs(tag, chk_perf);
  endtask

  task automatic idle_inputs();
    bp.fetch_valid = 0; bp.fetch_pc = 0; bp.exu_is_branch = 0;
    bp.exu_branch_taken = 0; bp.exu_branch_pc = 0; bp.exu_target_pc = 0;
    bp.bp_clear = 0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 1'b0;
    m_reset_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs(tag, 1'b1);
  endtask

  bit [31:0] base_mp;
  bit [31:0] rpc, rtgt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle_inputs();
    do_reset("rst");

    // Cold lookup falls through to pc+4.
    step("t1", 1, 32'h100, 0, 0, 0, 0, 0, 1);
    chk("t1_target", bp.pred_target, 32'h104);
    step("t1_hold", 0, 0, 0, 0, 0, 0, 0, 1);

    // Train taken twice, then hit.
    step("t2a", 0, 0, 1, 1, 32'h100, 32'h80, 0, 1);
    step("t2b", 0, 0, 1, 1, 32'h100, 32'h80, 0, 1);
    step("t2", 1, 32'h100, 0, 0, 0, 0, 0, 1);
    chk("t2_taken", {31'd0, bp.pred_taken}, 32'd1);
    chk("t2_target", bp.pred_target, 32'h80);

    // Detrain to 00; only the first two not-taken updates mispredict.
    base_mp = bp.perf_mispred_cnt;
    for (int i = 0; i < 4; i++) step("t3u", 0, 0, 1, 0, 32'h100, 0, 0, 1);
    chk("t3_mispred_delta", bp.perf_mispred_cnt - base_mp, 32'd2);
    step("t3", 1, 32'h100, 0, 0, 0, 0, 0, 1);
    chk("t3_taken", {31'd0, bp.pred_taken}, 32'd0);

    // Aliasing BTB entry replaces the tag.
    step("t4a", 0, 0, 1, 1, 32'h100, 32'h80, 0, 1);
    step("t4b", 0, 0, 1, 1, 32'h100 + 4 * NBTB, 32'h40, 0, 1);
    step("t4", 1, 32'h100, 0, 0, 0, 0, 0, 1);
    chk("t4_target", bp.pred_target, 32'h104);

    // Read-before-write, then visible next cycle; clear beats update.
    step("t5a", 1, 32'h100, 1, 1, 32'h100, 32'h80, 0, 1);
    chk("t5a_taken", {31'd0, bp.pred_taken}, 32'd0);
    step("t5b", 1, 32'h100, 0, 0, 0, 0, 0, 1);
    chk("t5b_target", bp.pred_target, 32'h80);
    step("t5c", 0, 0, 1, 1, 32'h100, 32'h80, 1, 0);
    step("t5d", 1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("t5d_target", bp.pred_target, 32'h104);
    do_reset("rst2");

    // Randomized traffic over a small pc pool so entries collide and retrain.
    for (int i = 0; i < 500; i++) begin
      bit fv, br, tk, clr;
      bit [31:0] fpc;
      fv  = ($urandom_range(0, 9) < 7);
      br  = ($urandom_range(0, 1) == 1);
      tk  = ($urandom_range(0, 2) != 0);
      clr = !br && ($urandom_range(0, 49) == 0);
      fpc = ($urandom_range(0, 1) << 12) | ($urandom_range(0, 23) << 2) | $urandom_range(0, 3) * ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 1) << 12) | ($urandom_range(0, 23) << 2);
      rtgt = 32'h8000 + ((rpc & 32'hFF) << 4) + ($urandom_range(0, 3) == 0 ? 32'h4 : 32'h0);
      if ($urandom_range(0, 1) == 1) fpc = rpc;
      step("rnd", fv, fpc, br, tk, rpc, rtgt, clr, 1);
    end

    // Saturation of the branch counter from just below the top.
    force dut.perf_branch_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.perf_branch_cnt_q;
    m_br = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step("t6sat", 0, 0, 1, 1, 32'h200, 32'h300, 0, 1);
    chk("t6_sat", bp.perf_branch_cnt, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of an update cycle.
    step("t6pre", 1, 32'h200, 1, 1, 32'h200, 32'h300, 0, 1);
    bp.exu_is_branch = 1; bp.exu_branch_taken = 1;
    bp.exu_branch_pc = 32'h200; bp.exu_target_pc = 32'h300; bp.fetch_valid = 1;
    #3;
    rst_n = 1'b0;
    #1;
    m_reset_all();
    check_outputs("t6rst", 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("t6post", 1, 32'h200, 0, 0, 0, 0, 0, 1);
    chk("t6post_target", bp.pred_target, 32'h204);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
